// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issue-side controller for the combinational FPU.
// Accepts one instruction at a time, reads its operands, holds the FPU inputs
// stable for an op-dependent settle time, captures the result and issues a
// single-cycle register-file writeback.
// Optional build macro: FPU_SEQ_FASTWB_EN (accept in WB plus writeback forwarding).
module fpu_sequencer #(
    parameter int unsigned ADD_LAT  = 2,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 6,
    parameter int unsigned SQRT_LAT = 6,
    parameter int unsigned CONV_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_ctrl,
    input  logic [5:0]  req_ds,
    input  logic [5:0]  req_dt,
    input  logic [5:0]  req_dd,
    input  logic [15:0] req_imm,
    output logic [5:0]  rs_addr,
    output logic [5:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [3:0]  fpu_ctrl,
    output logic [31:0] fpu_ds_val,
    output logic [31:0] fpu_dt_val,
    output logic [5:0]  fpu_dd,
    output logic [15:0] fpu_imm,
    input  logic [5:0]  fpu_reg_addr,
    input  logic [31:0] fpu_dd_val,
    output logic        wb_en,
    output logic [5:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        accept;
    logic [31:0] ds_sel, dt_sel;

    // Settle cycles needed by each op before the FPU output may be captured.
    function automatic logic [7:0] lat_of(input logic [3:0] ctrl);
        case (ctrl)
            4'd1, 4'd2:  lat_of = 8'(ADD_LAT);
            4'd3:        lat_of = 8'(MUL_LAT);
            4'd4:        lat_of = 8'(DIV_LAT);
            4'd5:        lat_of = 8'(SQRT_LAT);
            4'd9, 4'd10: lat_of = 8'(CONV_LAT);
            default:     lat_of = 8'd1;
        endcase
    endfunction

    assign rs_addr = req_ds;
    assign rt_addr = req_dt;
    assign busy    = (state != IDLE);
    assign wb_en   = (state == WB) && (wb_addr != 6'd0);

`ifdef FPU_SEQ_FASTWB_EN
    // In WB the register file has not committed yet, so a read of the
    // register being written must take the pending writeback value.
    assign req_ready = (state == IDLE) || (state == WB);
    assign ds_sel    = (state == WB && wb_addr != 6'd0 && req_ds == wb_addr) ? wb_data : rs_data;
    assign dt_sel    = (state == WB && wb_addr != 6'd0 && req_dt == wb_addr) ? wb_data : rt_data;
`else
    assign req_ready = (state == IDLE);
    assign ds_sel    = rs_data;
    assign dt_sel    = rt_data;
`endif

    assign accept = req_valid && req_ready;

    // Next-state and settle-counter logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = EXEC;
                    cnt_nx   = lat_of(req_ctrl) - 8'd1;
                end
            end
            EXEC: begin
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else begin
                    state_nx = WB;
                end
            end
            WB: begin
                if (accept) begin
                    state_nx = EXEC;
                    cnt_nx   = lat_of(req_ctrl) - 8'd1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // FPU input registers load on accept and are otherwise held; the result
    // is captured on the last settle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_ctrl   <= 4'd0;
            fpu_ds_val <= 32'd0;
            fpu_dt_val <= 32'd0;
            fpu_dd     <= 6'd0;
            fpu_imm    <= 16'd0;
            wb_addr    <= 6'd0;
            wb_data    <= 32'd0;
        end else begin
            if (accept) begin
                fpu_ctrl   <= req_ctrl;
                fpu_ds_val <= ds_sel;
                fpu_dt_val <= dt_sel;
                fpu_dd     <= req_dd;
                fpu_imm    <= req_imm;
            end
            if (state == EXEC && cnt == 8'd0) begin
                wb_addr <= fpu_reg_addr;
                wb_data <= fpu_dd_val;
            end
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: self-checking bench for fpu_sequencer with a register-file
// model, a behavioural FPU stub that only produces its result after the inputs
// have been stable for the op's settle time, and a transaction-level model.
module tb_fpu_sequencer;

    localparam int ADD_LAT  = 2;
    localparam int MUL_LAT  = 2;
    localparam int DIV_LAT  = 6;
    localparam int SQRT_LAT = 6;
    localparam int CONV_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_ctrl;
    logic [5:0]  req_ds, req_dt, req_dd;
    logic [15:0] req_imm;
    logic [5:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [3:0]  fpu_ctrl;
    logic [31:0] fpu_ds_val, fpu_dt_val;
    logic [5:0]  fpu_dd;
    logic [15:0] fpu_imm;
    logic [5:0]  fpu_reg_addr;
    logic [31:0] fpu_dd_val;
    logic        wb_en;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [64];
    logic [31:0] ref_rf [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = 6'd0;
    logic [31:0] pre_data = 32'd0;
    int          stab = 0;
    logic [89:0] snap;

    always #5 clk = ~clk;

    fpu_sequencer #(
        .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT),
        .SQRT_LAT(SQRT_LAT), .CONV_LAT(CONV_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_ds(req_ds), .req_dt(req_dt), .req_dd(req_dd), .req_imm(req_imm),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .fpu_ctrl(fpu_ctrl), .fpu_ds_val(fpu_ds_val), .fpu_dt_val(fpu_dt_val),
        .fpu_dd(fpu_dd), .fpu_imm(fpu_imm),
        .fpu_reg_addr(fpu_reg_addr), .fpu_dd_val(fpu_dd_val),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
    );

    function automatic int lat_of(input logic [3:0] c);
        case (c)
            4'd1, 4'd2:  return ADD_LAT;
            4'd3:        return MUL_LAT;
            4'd4:        return DIV_LAT;
            4'd5:        return SQRT_LAT;
            4'd9, 4'd10: return CONV_LAT;
            default:     return 1;
        endcase
    endfunction

    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'd0};
        else                   d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:30], 1'b1};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural FPU: what the unit produces once its inputs have settled.
    function automatic logic [31:0] fpu_fn(input logic [3:0] c, input logic [31:0] a, b,
                                           input logic [15:0] imm);
        real x, y;
        x = sp2r(a);
        y = sp2r(b);
        case (c)
            4'd1: return r2sp(x + y);
            4'd2: return r2sp(x - y);
            4'd3: return r2sp(x * y);
            4'd4: return r2sp(x / y);
            4'd5: return r2sp($sqrt(x));
            4'd6: return {31'd0, x == y};
            4'd7: return {31'd0, x < y};
            4'd8: return {31'd0, x <= y};
            4'd9: begin
                if (x != x) return 32'd0;
                if (x >= 2147483647.0) return 32'h7FFF_FFFF;
                if (x <= -2147483648.0) return 32'h8000_0000;
                return 32'($rtoi(x));
            end
            4'd10: return r2sp(real'($signed(a)));
            4'd11, 4'd12, 4'd13, 4'd14: return {a[31:16] ^ imm, b[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    // Register file: preload port for the bench, writeback port for the DUT.
    always @(posedge clk) begin
        if (pre_en) rf[pre_addr] <= pre_data;
        else if (wb_en) rf[wb_addr] <= wb_data;
    end
    assign rs_data = rf[rs_addr];
    assign rt_data = rf[rt_addr];

    // Count how long the FPU inputs have been unchanged.
    always @(negedge clk) begin
        if ({fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_dd, fpu_imm} !== snap) begin
            snap = {fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_dd, fpu_imm};
            stab = 1;
        end else if (stab < 1000) begin
            stab = stab + 1;
        end
    end

    // FPU stub: garbage until the inputs have been stable long enough.
    always_comb begin
        fpu_reg_addr = (fpu_ctrl == 4'd0 || fpu_ctrl == 4'd15) ? 6'd0 : fpu_dd;
        if (stab >= lat_of(fpu_ctrl)) fpu_dd_val = fpu_fn(fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_imm);
        else                          fpu_dd_val = 32'hBAD0_0000 | 32'(stab);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
        ref_rf[a] = d;
    endtask

    // Issue one op and check its handshake timing, the held FPU inputs and
    // the writeback position; returns what was written back.
    task automatic do_op(input logic [3:0] c, input logic [5:0] ds, dt, dd, input logic [15:0] imm,
                         input string tag, output int wb_n, output logic [5:0] wa, output logic [31:0] wd);
        int lat, wb_cyc, busy_n, rdy_cyc, bad_hold, exp_rdy;
        logic [31:0] ea, eb;
        bit acc;
        lat = lat_of(c); ea = ref_rf[ds]; eb = ref_rf[dt];
        wb_n = 0; wb_cyc = 0; busy_n = 0; rdy_cyc = 0; bad_hold = 0; wa = 6'd0; wd = 32'd0; acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) begin
                req_ctrl = c; req_ds = ds; req_dt = dt; req_dd = dd; req_imm = imm;
                req_valid = 1'b1; acc = 1'b1;
            end
        end
        chk({tag, " accepted"}, 32'(acc), 32'd1);
        if (!acc) return;
        #1;
        chk({tag, " rs_addr"}, 32'(rs_addr), 32'(ds));
        chk({tag, " rt_addr"}, 32'(rt_addr), 32'(dt));
        @(posedge clk);
        #1 req_valid = 1'b0;
`ifndef FPU_SEQ_FASTWB_EN
        // A different request presented while busy must be ignored.
        req_valid = 1'b1; req_ctrl = 4'($urandom); req_ds = 6'($urandom);
        req_dt = 6'($urandom); req_dd = 6'($urandom); req_imm = 16'($urandom);
`endif
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (wb_en) begin wb_n++; wb_cyc = k; wa = wb_addr; wd = wb_data; end
            if (busy) busy_n++;
            if (k <= lat && {fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_dd, fpu_imm} !== {c, ea, eb, dd, imm})
                bad_hold++;
            if (req_ready) begin rdy_cyc = k; break; end
        end
        req_valid = 1'b0;
`ifdef FPU_SEQ_FASTWB_EN
        exp_rdy = lat + 1;
`else
        exp_rdy = lat + 2;
`endif
        chk({tag, " ready_cycle"}, 32'(rdy_cyc), 32'(exp_rdy));
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(lat + 1));
        chk({tag, " inputs_held"}, 32'(bad_hold), 32'd0);
        if (wb_n != 0) chk({tag, " wb_cycle"}, 32'(wb_cyc), 32'(lat + 1));
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [5:0]  ds, dt, dd;
        logic [15:0] imm;
        logic [31:0] a, b;
        bit          w;
        logic [31:0] d;
    } vec_t;

    vec_t vt[10];

    initial begin
        int wn, mism;
        logic [5:0] wa;
        logic [31:0] wd;
        bit acc;

        vt[0] = '{4'd1,  6'd1, 6'd2, 6'd5,  16'h0000, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000};
        vt[1] = '{4'd4,  6'd1, 6'd2, 6'd6,  16'h0000, 32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000};
        vt[2] = '{4'd0,  6'd1, 6'd2, 6'd9,  16'h0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0};
        vt[3] = '{4'd15, 6'd1, 6'd2, 6'd9,  16'h0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0};
        vt[4] = '{4'd7,  6'd1, 6'd2, 6'd4,  16'h0000, 32'hBF80_0000, 32'h0000_0000, 1'b1, 32'h0000_0001};
        vt[5] = '{4'd3,  6'd1, 6'd2, 6'd10, 16'h0000, 32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000};
        vt[6] = '{4'd2,  6'd1, 6'd2, 6'd11, 16'h0000, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000};
        vt[7] = '{4'd1,  6'd1, 6'd2, 6'd0,  16'h0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h0};
        vt[8] = '{4'd11, 6'd1, 6'd2, 6'd12, 16'h1234, 32'hAAAA_5555, 32'h0000_FFFF, 1'b1, 32'hB89E_FFFF};
        vt[9] = '{4'd5,  6'd1, 6'd2, 6'd13, 16'h0000, 32'h4080_0000, 32'h0000_0000, 1'b1, 32'h4000_0000};

        rst = 1'b1; req_valid = 1'b0; req_ctrl = 4'd0; req_ds = 6'd0; req_dt = 6'd0;
        req_dd = 6'd0; req_imm = 16'd0;
        for (int i = 0; i < 64; i++)
            preload(6'(i), {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)});

        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset wb_en", 32'(wb_en), 32'd0);
        chk("reset wb_addr", 32'(wb_addr), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset fpu_ctrl", 32'(fpu_ctrl), 32'd0);
        chk("reset fpu_ds_val", fpu_ds_val, 32'd0);
        chk("reset fpu_dt_val", fpu_dt_val, 32'd0);
        chk("reset fpu_dd", 32'(fpu_dd), 32'd0);
        chk("reset fpu_imm", 32'(fpu_imm), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            preload(vt[i].ds, vt[i].a);
            preload(vt[i].dt, vt[i].b);
            do_op(vt[i].c, vt[i].ds, vt[i].dt, vt[i].dd, vt[i].imm, $sformatf("vec%0d", i), wn, wa, wd);
            chk($sformatf("vec%0d wb_count", i), 32'(wn), 32'(vt[i].w));
            if (vt[i].w) begin
                chk($sformatf("vec%0d wb_addr", i), 32'(wa), 32'(vt[i].dd));
                chk($sformatf("vec%0d wb_data", i), wd, vt[i].d);
                ref_rf[vt[i].dd] = vt[i].d;
            end
        end

        // Reset in cycle 3 of an fsqrt aborts it.
        @(negedge clk);
        preload(6'd6, 32'h4080_0000);
        preload(6'd7, 32'h1234_5678);
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) begin
                req_ctrl = 4'd5; req_ds = 6'd6; req_dt = 6'd6; req_dd = 6'd7; req_imm = 16'd0;
                req_valid = 1'b1; acc = 1'b1;
            end
        end
        chk("abort accepted", 32'(acc), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        chk("abort fpu_ctrl", 32'(fpu_ctrl), 32'd0);
        wn = 0;
        for (int k = 0; k < 10; k++) begin
            if (wb_en) wn++;
            @(negedge clk);
        end
        chk("abort no_wb", 32'(wn), 32'd0);
        chk("abort r7 kept", rf[7], 32'h1234_5678);

        // Randomized ops against the transaction model.
        for (int n = 0; n < 50; n++) begin
            logic [3:0] c;
            logic [5:0] ds, dt, dd;
            logic [15:0] imm;
            logic [31:0] ed;
            bit ew;
            c = 4'($urandom); ds = 6'($urandom); dt = 6'($urandom);
            dd = 6'($urandom); imm = 16'($urandom);
            ew = (c != 4'd0) && (c != 4'd15) && (dd != 6'd0);
            ed = fpu_fn(c, ref_rf[ds], ref_rf[dt], imm);
            do_op(c, ds, dt, dd, imm, $sformatf("rnd%0d", n), wn, wa, wd);
            chk($sformatf("rnd%0d wb_count", n), 32'(wn), 32'(ew));
            if (ew) begin
                chk($sformatf("rnd%0d wb_addr", n), 32'(wa), 32'(dd));
                chk($sformatf("rnd%0d wb_data", n), wd, ed);
                ref_rf[dd] = ed;
            end
        end

`ifdef FPU_SEQ_FASTWB_EN
        // Back-to-back dependent ops: second is accepted in WB with forwarding.
        @(negedge clk);
        @(negedge clk);
        preload(6'd1, 32'h4000_0000);
        preload(6'd2, 32'h4040_0000);
        @(negedge clk);
        req_ctrl = 4'd3; req_ds = 6'd1; req_dt = 6'd2; req_dd = 6'd3; req_imm = 16'd0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_ctrl = 4'd1; req_ds = 6'd3; req_dt = 6'd3; req_dd = 6'd4;
        repeat (MUL_LAT + 1) @(negedge clk);
        chk("fastwb ready_in_wb", 32'(req_ready), 32'd1);
        chk("fastwb wb_en", 32'(wb_en), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("fastwb fwd_ds", fpu_ds_val, 32'h40C0_0000);
        chk("fastwb fwd_dt", fpu_dt_val, 32'h40C0_0000);
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        chk("fastwb idle", 32'(busy), 32'd0);
        chk("fastwb r3", rf[3], 32'h40C0_0000);
        chk("fastwb r4", rf[4], 32'h4140_0000);
        ref_rf[3] = 32'h40C0_0000;
        ref_rf[4] = 32'h4140_0000;
`endif

        // Final register-file contents against the model.
        repeat (3) @(negedge clk);
        mism = 0;
        for (int i = 0; i < 64; i++) if (rf[i] !== ref_rf[i]) mism++;
        chk("regfile contents", 32'(mism), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
